// File: rtl/vector_mul_pipe.sv
// vector_mul_pipe
//   Three-stage WIDTHxWIDTH integer multiplier. Each operand can be signed or
//   unsigned. A tag travels with each operation. Full valid/ready backpressure
//   and a synchronous flush are supported.
//   The product is assembled from NL*NL 17x17 signed limb products, where
//   NL = WIDTH/16, so no wide multiplier is inferred.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       drop all in-flight operations on the next edge
//   in_valid_i / in_ready_o       operation handshake
//   in_a_i, in_b_i                operands (WIDTH bits each)
//   in_a_signed_i, in_b_signed_i  per-operand two's complement flag
//   in_tag_i                      opaque tag, returned with the result
//   out_valid_o / out_ready_i     result handshake
//   out_result_o                  2*WIDTH product (zero when out_valid_o=0)
//   out_tag_o                     tag of the result (zero when out_valid_o=0)

module vector_mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic               in_a_signed_i,
  input  logic               in_b_signed_i,
  input  logic [TAG_W-1:0]   in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] out_result_o,
  output logic [TAG_W-1:0]   out_tag_o
);

  localparam int NL    = WIDTH / 16;
  localparam int NP    = NL * NL;
  localparam int RW    = 2 * WIDTH;
  // Each limb product is 34 bits. It is sign-extended to at least the result
  // width before shifting. When WIDTH=16 the result is narrower than one limb
  // product, and the top bits are dropped (the sum is taken mod 2^RW).
  localparam int EXT_W = (RW > 34) ? RW : 34;

  // S1: operands, sign flags, tag
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_signed_q, b_signed_q;
  logic [TAG_W-1:0] tag1_q;

  // S2: limb products
  logic               v2_q, v2_d;
  logic signed [33:0] pp_q [NP];
  logic [TAG_W-1:0]   tag2_q;

  // S3: summed result
  logic             v3_q, v3_d;
  logic [RW-1:0]    res_q;
  logic [TAG_W-1:0] tag3_q;

  logic ld1, ld2, ld3, accept;

  logic signed [16:0] a_limb [NL];
  logic signed [16:0] b_limb [NL];
  logic signed [33:0] pp_d   [NP];

  logic signed [EXT_W-1:0] term;
  logic        [EXT_W-1:0] shifted;
  logic        [RW-1:0]    sum_d;

  // The ready chain is combinational from out_ready_i back to in_ready_o.
  // A full pipeline can therefore accept one operation and drain one in the
  // same cycle.
  assign ld3        = !v3_q || out_ready_i;
  assign ld2        = !v2_q || ld3;
  assign ld1        = !v1_q || ld2;
  assign in_ready_o = ld1 && !flush_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (ld3) v3_d = v2_q;
    if (ld2) v2_d = v1_q;
    if (ld1) v1_d = accept;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  // Only the top limb carries the sign extension bit. All lower limbs are
  // unsigned 16-bit digits with a zero 17th bit.
  for (genvar i = 0; i < NL; i++) begin : g_limb
    if (i == NL - 1) begin : g_top
      assign a_limb[i] = {a_signed_q & a_q[WIDTH-1], a_q[16*i +: 16]};
      assign b_limb[i] = {b_signed_q & b_q[WIDTH-1], b_q[16*i +: 16]};
    end else begin : g_low
      assign a_limb[i] = {1'b0, a_q[16*i +: 16]};
      assign b_limb[i] = {1'b0, b_q[16*i +: 16]};
    end
  end

  for (genvar i = 0; i < NL; i++) begin : g_pp_row
    for (genvar j = 0; j < NL; j++) begin : g_pp_col
      assign pp_d[i*NL+j] = 34'(a_limb[i]) * 34'(b_limb[j]);
    end
  end

  always_comb begin
    sum_d   = '0;
    term    = '0;
    shifted = '0;
    for (int k = 0; k < NP; k++) begin
      term    = EXT_W'(pp_q[k]);
      shifted = term << (16 * ((k / NL) + (k % NL)));
      sum_d   = sum_d + shifted[RW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_signed_q <= 1'b0;
      b_signed_q <= 1'b0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      tag3_q     <= '0;
      res_q      <= '0;
      for (int k = 0; k < NP; k++) pp_q[k] <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (accept) begin
        a_q        <= in_a_i;
        b_q        <= in_b_i;
        a_signed_q <= in_a_signed_i;
        b_signed_q <= in_b_signed_i;
        tag1_q     <= in_tag_i;
      end
      if (ld2 && v1_q) begin
        for (int k = 0; k < NP; k++) pp_q[k] <= pp_d[k];
        tag2_q <= tag1_q;
      end
      if (ld3 && v2_q) begin
        res_q  <= sum_d;
        tag3_q <= tag2_q;
      end
    end
  end

  assign out_valid_o  = v3_q;
  assign out_result_o = v3_q ? res_q  : '0;
  assign out_tag_o    = v3_q ? tag3_q : '0;

endmodule

// File: tb/tb_vector_mul_pipe.sv
module tb_vector_mul_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a, in_b;
  logic            in_as, in_bs;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_result;
  logic [TW-1:0]   out_tag;

  int total = 0;
  int bad   = 0;

  vector_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_a_signed_i(in_as),
    .in_b_signed_i(in_bs),
    .in_tag_i     (in_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_tag_o    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, input logic [TW-1:0] t);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_as    = sa;
    in_bs    = sb;
    in_tag   = t;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
    logic [2*W-1:0] ea, eb;
    ea = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b result=%h tag=%h want 0/0/0", out_valid, out_result, out_tag);
    end
    #12 rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd1);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL unsigned_accept: in_ready=%b want 1", in_ready);
    end
    step();
    idle();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_c1: out_valid=%b want 0", out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_c2: out_valid=%b want 0", out_valid);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFE_0000_0001 || out_tag !== 4'd1) begin
      bad++;
      $display("FAIL unsigned_max: valid=%b result=%h tag=%h want 1/fffffffe00000001/1",
               out_valid, out_result, out_tag);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL idle_zero: valid=%b result=%h tag=%h want 0/0/0", out_valid, out_result, out_tag);
    end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd2);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd3);
    step();
    idle();
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'h4000_0000_0000_0000 || out_tag !== 4'd2) begin
      bad++;
      $display("FAIL signed_min_sq: valid=%b result=%h tag=%h want 1/4000000000000000/2",
               out_valid, out_result, out_tag);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'h0000_0000_0000_0001 || out_tag !== 4'd3) begin
      bad++;
      $display("FAIL signed_m1_sq: valid=%b result=%h tag=%h want 1/0000000000000001/3",
               out_valid, out_result, out_tag);
    end
    step();
  endtask

  task automatic test_mixed();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 4'd4);
    step();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd5);
    step();
    idle();
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFFE || out_tag !== 4'd4) begin
      bad++;
      $display("FAIL mixed_s_u: valid=%b result=%h tag=%h want 1/fffffffffffffffe/4",
               out_valid, out_result, out_tag);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_0000_0001 || out_tag !== 4'd5) begin
      bad++;
      $display("FAIL mixed_u_s: valid=%b result=%h tag=%h want 1/ffffffff00000001/5",
               out_valid, out_result, out_tag);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int  acc;
    logic fire;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, W'(acc + 1), 32'd3, 1'b0, 1'b0, TW'(acc));
      #1;
      fire = in_ready;
      step();
      if (fire) acc++;
    end
    drive(1'b1, W'(acc + 1), 32'd3, 1'b0, 1'b0, TW'(acc));
    #1;
    total++;
    if (acc !== 3 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_capacity: accepted=%0d in_ready=%b want 3/0", acc, in_ready);
    end
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_result !== 64'd3) begin
      bad++;
      $display("FAIL stall_hold: valid=%b tag=%h result=%h want 1/0/3", out_valid, out_tag, out_result);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (acc < 5) drive(1'b1, W'(acc + 1), 32'd3, 1'b0, 1'b0, TW'(acc));
      else idle();
      #1;
      fire = in_valid && in_ready;
      total++;
      if (out_valid !== 1'b1 || out_tag !== TW'(k) || out_result !== 64'((k + 1) * 3)) begin
        bad++;
        $display("FAIL drain_order k=%0d: valid=%b tag=%h result=%h want 1/%h/%h",
                 k, out_valid, out_tag, out_result, TW'(k), 64'((k + 1) * 3));
      end
      step();
      if (fire) acc++;
    end
    idle();
    total++;
    if (out_valid !== 1'b0 || acc !== 5) begin
      bad++;
      $display("FAIL drain_end: valid=%b accepted=%0d want 0/5", out_valid, acc);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 32'd11, 32'd13, 1'b0, 1'b0, 4'd1);
    step();
    drive(1'b1, 32'd17, 32'd19, 1'b0, 1'b0, 4'd2);
    step();
    drive(1'b1, 32'd23, 32'd29, 1'b0, 1'b0, 4'd3);
    flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    step();
    flush = 1'b0;
    idle();
    for (int c = 0; c < 4; c++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_result c=%0d: out_valid=%b tag=%h want 0", c, out_valid, out_tag);
      end
      step();
    end
    drive(1'b1, 32'd7, 32'd6, 1'b0, 1'b0, 4'd9);
    step();
    idle();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_flush_c1: out_valid=%b want 0", out_valid);
    end
    step();
    step();
    total++;
    if (out_valid !== 1'b1 || out_result !== 64'd42 || out_tag !== 4'd9) begin
      bad++;
      $display("FAIL post_flush_op: valid=%b result=%h tag=%h want 1/2a/9", out_valid, out_result, out_tag);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(c + 5), 32'd5, 1'b0, 1'b0, TW'(c + 1));
      step();
    end
    idle();
    total++;
    if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_result !== 64'd25) begin
      bad++;
      $display("FAIL prereset_full: valid=%b tag=%h result=%h want 1/1/19", out_valid, out_tag, out_result);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL async_reset: valid=%b result=%h tag=%h want 0/0/0", out_valid, out_result, out_tag);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_empty c=%0d: out_valid=%b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [TW+2*W-1:0] q[$];
    logic [TW+2*W-1:0] exp_v;
    logic [TW+2*W-1:0] pend;
    logic fire_in, fire_out;
    int issued, cycles;
    logic [W-1:0] ra, rb;
    issued = 0;
    cycles = 0;
    while ((issued < N || q.size() != 0) && cycles < 5000) begin
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: ra = 32'h8000_0000;
        2: rb = 32'h7FFF_FFFF;
        3: rb = 32'h0;
        default: ;
      endcase
      if (issued < N)
        drive(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)));
      else
        idle();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      pend     = {in_tag, ref_mul(in_a, in_b, in_as, in_bs)};
      if (fire_out) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected: tag=%h result=%h with nothing outstanding", out_tag, out_result);
        end else begin
          exp_v = q.pop_front();
          if ({out_tag, out_result} !== exp_v) begin
            bad++;
            $display("FAIL rand_result: got tag=%h result=%h want tag=%h result=%h",
                     out_tag, out_result, exp_v[TW+2*W-1 -: TW], exp_v[2*W-1:0]);
          end
        end
      end else if (!out_valid) begin
        total++;
        if (out_result !== '0 || out_tag !== '0) begin
          bad++;
          $display("FAIL rand_idle_zero: result=%h tag=%h want 0/0", out_result, out_tag);
        end
      end
      step();
      cycles++;
      if (fire_in) begin
        q.push_back(pend);
        issued++;
      end
    end
    idle();
    total++;
    if (issued != N || q.size() != 0) begin
      bad++;
      $display("FAIL rand_timeout: issued=%0d outstanding=%0d want %0d/0", issued, q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
